// File: rtl/mem_module_pkg.sv
// Shared definitions for the MEM stage: opcodes, stage bus layout, FSM encodings.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mem_module_pkg;

   localparam logic [3:0] OP_LOAD  = 4'b1010;
   localparam logic [3:0] OP_STORE = 4'b1011;

   // exbus and membus share one layout; only the low field changes meaning
   // (store data on exbus, memory result on membus).
   typedef struct packed {
      logic        vld;   // [39]
      logic [3:0]  op;    // [38:35]
      logic [2:0]  dest;  // [34:32]
      logic [15:0] res;   // [31:16] ALU value / memory address
      logic [15:0] dat;   // [15:0]  store data (exbus) / memresult (membus)
   } stage_bus_t;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACCESS = 1'b1;

   function automatic logic is_mem_op(input logic [3:0] op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

endpackage

// File: rtl/mem_module_dmem_port.sv
// Data-memory port: ACCESS FSM, req/ack hold, timeout abort, result selection.
// Latency: req rises the cycle after i_start; o_done is combinational in the ack/timeout cycle.
// Backpressure: o_idle low while an access is outstanding; dmem request held until ack or timeout.
// Ports: i_start/i_wr/i_addr/i_wdata launch an access; o_done/o_memresult report its end;
//        o_dmem_* / i_dmem_* form the memory req/ack interface; o_mem_err is sticky.
module mem_module_dmem_port
   import mem_module_pkg::*;
#(
   parameter int          ACK_TIMEOUT = 16,
   parameter logic [15:0] ERR_DATA    = 16'hDEAD
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic        i_wr,
   input  logic [15:0] i_addr,
   input  logic [15:0] i_wdata,
   input  logic [15:0] i_dmem_rdata,
   input  logic        i_dmem_ack,
   output logic        o_idle,
   output logic        o_done,
   output logic [15:0] o_memresult,
   output logic        o_dmem_req,
   output logic        o_dmem_wr,
   output logic [15:0] o_dmem_addr,
   output logic [15:0] o_dmem_wdata,
   output logic        o_mem_err
);

   localparam int             CW       = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(ACK_TIMEOUT - 1);
   localparam logic [CW-1:0]  CNT_MAX  = CW'(ACK_TIMEOUT);

   logic [0:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic          r_wr;
   logic [15:0]   r_addr;
   logic [15:0]   r_wdata;
   logic          r_err;

   logic w_access;
   logic w_ack;
   logic w_timeout;

   assign w_access  = (r_state == ST_ACCESS);
   assign w_ack     = w_access & i_dmem_ack;
   // r_cnt counts completed req cycles, so CNT_LAST marks the final allowed one.
   // An ack in that same cycle takes priority over the abort.
   assign w_timeout = w_access & ~i_dmem_ack & (r_cnt == CNT_LAST);

   assign o_idle       = ~w_access;
   assign o_done       = w_ack | w_timeout;
   assign o_memresult  = r_wr  ? 16'h0 :
                         w_ack ? i_dmem_rdata : ERR_DATA;
   assign o_dmem_req   = w_access;
   assign o_dmem_wr    = r_wr;
   assign o_dmem_addr  = r_addr;
   assign o_dmem_wdata = r_wdata;
   assign o_mem_err    = r_err;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_wr    <= 1'b0;
         r_addr  <= 16'h0;
         r_wdata <= 16'h0;
         r_err   <= 1'b0;
      end else if (!w_access) begin
         if (i_start) begin
            r_state <= ST_ACCESS;
            r_cnt   <= '0;
            r_wr    <= i_wr;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
         end
      end else begin
         if (o_done) begin
            r_state <= ST_IDLE;
            if (w_timeout) r_err <= 1'b1;
         end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/mem_module.sv
// MEM pipeline stage: registers EX result, runs LOAD/STORE over dmem req/ack, drives membus to WB.
// Latency: non-memory ops 1 cycle; LOAD/STORE 1 + ack delay (min 2) or 1 + ACK_TIMEOUT on abort.
// Backpressure: o_mem_allowin low while a memory access is outstanding; membus has no handshake.
// Ports: i_exbus in (40b), o_mem_allowin, o_membus out (40b, valid is a 1-cycle pulse),
//        o_dmem_req/wr/addr/wdata + i_dmem_rdata/ack memory port, o_mem_err sticky abort flag.
module mem_module
   import mem_module_pkg::*;
#(
   parameter int          ACK_TIMEOUT = 16,
   parameter logic [15:0] ERR_DATA    = 16'hDEAD
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic [39:0] i_exbus,
   output logic        o_mem_allowin,
   output logic [39:0] o_membus,
   output logic        o_dmem_req,
   output logic        o_dmem_wr,
   output logic [15:0] o_dmem_addr,
   output logic [15:0] o_dmem_wdata,
   input  logic [15:0] i_dmem_rdata,
   input  logic        i_dmem_ack,
   output logic        o_mem_err
);

   stage_bus_t  w_ex;
   stage_bus_t  r_membus;
   logic [3:0]  r_op;
   logic [2:0]  r_dest;

   logic        w_accept;
   logic        w_is_mem;
   logic        w_start;
   logic        w_done;
   logic [15:0] w_memresult;

   assign w_ex     = i_exbus;
   assign w_accept = o_mem_allowin & w_ex.vld;
   assign w_is_mem = is_mem_op(w_ex.op);
   assign w_start  = w_accept & w_is_mem;
   assign o_membus = r_membus;

   mem_module_dmem_port #(
      .ACK_TIMEOUT (ACK_TIMEOUT),
      .ERR_DATA    (ERR_DATA)
   ) u_dmem_port (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_start      (w_start),
      .i_wr         (w_ex.op == OP_STORE),
      .i_addr       (w_ex.res),
      .i_wdata      (w_ex.dat),
      .i_dmem_rdata (i_dmem_rdata),
      .i_dmem_ack   (i_dmem_ack),
      .o_idle       (o_mem_allowin),
      .o_done       (w_done),
      .o_memresult  (w_memresult),
      .o_dmem_req   (o_dmem_req),
      .o_dmem_wr    (o_dmem_wr),
      .o_dmem_addr  (o_dmem_addr),
      .o_dmem_wdata (o_dmem_wdata),
      .o_mem_err    (o_mem_err)
   );

   // Accept and completion are mutually exclusive: allowin is low during ACCESS.
   // The latched address doubles as the exresult field of the completed instruction.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_membus <= '0;
         r_op     <= 4'h0;
         r_dest   <= 3'h0;
      end else begin
         r_membus.vld <= 1'b0;
         if (w_accept && !w_is_mem) begin
            r_membus <= '{vld: 1'b1, op: w_ex.op, dest: w_ex.dest, res: w_ex.res, dat: 16'h0};
         end else if (w_done) begin
            r_membus <= '{vld: 1'b1, op: r_op, dest: r_dest, res: o_dmem_addr, dat: w_memresult};
         end
         if (w_start) begin
            r_op   <= w_ex.op;
            r_dest <= w_ex.dest;
         end
      end
   end

endmodule
